// File: rtl/synth_sample_scheduler.sv
// Sample-rate sequencer: derives the audio tick, snapshots the parser outputs once per
// sample and walks the generator, filter, envelope and DAC stages through start/done handshakes.
module synth_sample_scheduler #(
  parameter int unsigned TICK_DIVIDER  = 1134,
  parameter int unsigned STAGE_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] inFrequency,
  input  logic [6:0]  inVelocity,
  input  logic        inPlaying,
  output logic [23:0] outFrequency,
  output logic [6:0]  outVelocity,
  output logic        outPlaying,
  output logic        outGenStart,
  input  logic        inGenDone,
  output logic        outFiltStart,
  input  logic        inFiltDone,
  output logic        outEnvStart,
  input  logic        inEnvDone,
  output logic        outDacStart,
  input  logic        inDacDone,
  output logic        outBusy,
  output logic [7:0]  outOverrunCount,
  output logic        outTimeout
);

  typedef enum logic [2:0] {IDLE, GEN, FILT, ENV, DAC} stateT;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIVIDER - 1);
  localparam logic [15:0] WAIT_LAST = 16'(STAGE_TIMEOUT - 1);

  stateT       state;
  stateT       nextState;
  logic [15:0] tickCount;
  logic [15:0] waitCount;
  logic        tick;
  logic        stageDone;
  logic        waitExpired;
  logic        genStartNext;
  logic        filtStartNext;
  logic        envStartNext;
  logic        dacStartNext;

  assign tick = (tickCount == TICK_LAST);

  // The sample tick free-runs regardless of what the stage chain is doing.
  always_ff @(posedge clock) begin
    if (reset) begin
      tickCount <= '0;
    end else if (tick) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + 16'd1;
    end
  end

  // Only the done of the stage currently being waited on is looked at; a done in the
  // last permitted wait cycle beats the timeout.
  always_comb begin
    nextState     = state;
    stageDone     = 1'b0;
    genStartNext  = 1'b0;
    filtStartNext = 1'b0;
    envStartNext  = 1'b0;
    dacStartNext  = 1'b0;

    case (state)
      GEN:     stageDone = inGenDone;
      FILT:    stageDone = inFiltDone;
      ENV:     stageDone = inEnvDone;
      DAC:     stageDone = inDacDone;
      default: stageDone = 1'b0;
    endcase

    waitExpired = (state != IDLE) && !stageDone && (waitCount == WAIT_LAST);

    case (state)
      IDLE: begin
        if (tick) begin
          nextState    = GEN;
          genStartNext = 1'b1;
        end
      end
      GEN: begin
        if (stageDone) begin
          nextState     = FILT;
          filtStartNext = 1'b1;
        end else if (waitExpired) begin
          nextState = IDLE;
        end
      end
      FILT: begin
        if (stageDone) begin
          nextState    = ENV;
          envStartNext = 1'b1;
        end else if (waitExpired) begin
          nextState = IDLE;
        end
      end
      ENV: begin
        if (stageDone) begin
          nextState    = DAC;
          dacStartNext = 1'b1;
        end else if (waitExpired) begin
          nextState = IDLE;
        end
      end
      DAC: begin
        if (stageDone || waitExpired) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // All handshake outputs are registered from the transition, so each start pulse
  // lands in the first cycle of its state and busy tracks the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      waitCount       <= '0;
      outFrequency    <= '0;
      outVelocity     <= '0;
      outPlaying      <= 1'b0;
      outGenStart     <= 1'b0;
      outFiltStart    <= 1'b0;
      outEnvStart     <= 1'b0;
      outDacStart     <= 1'b0;
      outBusy         <= 1'b0;
      outOverrunCount <= '0;
      outTimeout      <= 1'b0;
    end else begin
      state        <= nextState;
      waitCount    <= ((nextState != state) || (nextState == IDLE)) ? 16'd0 : waitCount + 16'd1;
      outGenStart  <= genStartNext;
      outFiltStart <= filtStartNext;
      outEnvStart  <= envStartNext;
      outDacStart  <= dacStartNext;
      outBusy      <= (nextState != IDLE);
      outTimeout   <= waitExpired;

      if ((state == IDLE) && tick) begin
        outFrequency <= inFrequency;
        outVelocity  <= inVelocity;
        outPlaying   <= inPlaying;
      end

      // A tick that finds the chain busy is dropped, including one in the DAC->IDLE cycle.
      if (tick && (state != IDLE) && (outOverrunCount != 8'hFF)) begin
        outOverrunCount <= outOverrunCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_synth_sample_scheduler.sv
// Self-checking bench for synth_sample_scheduler: a sample-level event model predicts
// every output cycle by cycle while directed scenarios check the key timing points.
module tb_synth_sample_scheduler;

  localparam int TDIV = 16;
  localparam int TOUT = 8;
  localparam int MAXC = 8192;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] inFrequency;
  logic [6:0]  inVelocity;
  logic        inPlaying;
  logic [23:0] outFrequency;
  logic [6:0]  outVelocity;
  logic        outPlaying;
  logic        outGenStart;
  logic        inGenDone;
  logic        outFiltStart;
  logic        inFiltDone;
  logic        outEnvStart;
  logic        inEnvDone;
  logic        outDacStart;
  logic        inDacDone;
  logic        outBusy;
  logic [7:0]  outOverrunCount;
  logic        outTimeout;

  always #5 clock = ~clock;

  synth_sample_scheduler #(
    .TICK_DIVIDER (TDIV),
    .STAGE_TIMEOUT(TOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inFrequency    (inFrequency),
    .inVelocity     (inVelocity),
    .inPlaying      (inPlaying),
    .outFrequency   (outFrequency),
    .outVelocity    (outVelocity),
    .outPlaying     (outPlaying),
    .outGenStart    (outGenStart),
    .inGenDone      (inGenDone),
    .outFiltStart   (outFiltStart),
    .inFiltDone     (inFiltDone),
    .outEnvStart    (outEnvStart),
    .inEnvDone      (inEnvDone),
    .outDacStart    (outDacStart),
    .inDacDone      (inDacDone),
    .outBusy        (outBusy),
    .outOverrunCount(outOverrunCount),
    .outTimeout     (outTimeout)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Expected events per cycle since reset release, filled in whenever a sample starts.
  byte startArr   [MAXC];
  byte doneArr    [MAXC];
  byte stageArr   [MAXC];
  bit  busyArr    [MAXC];
  bit  timeoutArr [MAXC];

  int          cyc = 0;
  bit          resetPending = 1'b0;
  int          idleAt = 0;
  int          expOver = 0;
  logic [23:0] expFreq = '0;
  logic [6:0]  expVel = '0;
  logic        expPlay = 1'b0;
  logic [45:0] expVec = '0;

  logic        drvReset;
  logic [23:0] drvFreq;
  logic [6:0]  drvVel;
  logic        drvPlay;
  int          delayLo [1:4];
  int          delayHi [1:4];
  bit          spurAll = 1'b0;
  bit          spurRand = 1'b0;

  function automatic logic [45:0] actVec();
    return {outGenStart, outFiltStart, outEnvStart, outDacStart, outBusy, outTimeout,
            outOverrunCount, outPlaying, outVelocity, outFrequency};
  endfunction

  task automatic setDelays(input int g, input int f, input int e, input int d);
    delayLo[1] = g; delayHi[1] = g;
    delayLo[2] = f; delayHi[2] = f;
    delayLo[3] = e; delayHi[3] = e;
    delayLo[4] = d; delayHi[4] = d;
  endtask

  task automatic modelReset();
    for (int i = 0; i < MAXC; i++) begin
      startArr[i]   = 0;
      doneArr[i]    = 0;
      stageArr[i]   = 0;
      busyArr[i]    = 1'b0;
      timeoutArr[i] = 1'b0;
    end
    idleAt  = 0;
    expOver = 0;
    expFreq = '0;
    expVel  = '0;
    expPlay = 1'b0;
    cyc     = 0;
  endtask

  // A stage answering within the timeout hands over one cycle after its done;
  // a stage that stays silent for TOUT cycles ends the sample with a timeout pulse.
  task automatic scheduleSample(input int n);
    int s;
    int d;
    s = n + 1;
    for (int k = 1; k <= 4; k++) begin
      d = (delayLo[k] == delayHi[k]) ? delayLo[k] : int'($urandom_range(delayHi[k], delayLo[k]));
      startArr[s] = startArr[s] | byte'(1 << (k - 1));
      if (d < TOUT) begin
        for (int c = s; c <= s + d; c++) begin
          stageArr[c] = byte'(k);
          busyArr[c]  = 1'b1;
        end
        doneArr[s + d] = doneArr[s + d] | byte'(1 << (k - 1));
        s = s + d + 1;
      end else begin
        for (int c = s; c < s + TOUT; c++) begin
          stageArr[c] = byte'(k);
          busyArr[c]  = 1'b1;
        end
        timeoutArr[s + TOUT] = 1'b1;
        s = s + TOUT;
        break;
      end
    end
    idleAt = s;
  endtask

  // Advances one clock: snapshots the expected outputs for this cycle, then drives
  // this cycle's inputs and lets the model react to a tick.
  task automatic stepCycle();
    logic [3:0] sp;
    @(negedge clock);
    if (resetPending) modelReset();
    else cyc++;
    resetPending = 1'b0;
    expVec = {startArr[cyc][0], startArr[cyc][1], startArr[cyc][2], startArr[cyc][3],
              busyArr[cyc], timeoutArr[cyc], 8'(expOver), expPlay, expVel, expFreq};
    reset       = drvReset;
    inFrequency = drvFreq;
    inVelocity  = drvVel;
    inPlaying   = drvPlay;
    {inDacDone, inEnvDone, inFiltDone, inGenDone} = 4'b0000;
    if (drvReset) begin
      resetPending = 1'b1;
      return;
    end
    if (cyc % TDIV == TDIV - 1) begin
      if (cyc >= idleAt) begin
        expFreq = drvFreq;
        expVel  = drvVel;
        expPlay = drvPlay;
        scheduleSample(cyc);
      end else if (expOver < 255) begin
        expOver++;
      end
    end
    sp = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      if ((int'(stageArr[cyc]) != k) && (spurAll || (spurRand && ($urandom_range(3, 0) == 0))))
        sp[k - 1] = 1'b1;
    end
    {inDacDone, inEnvDone, inFiltDone, inGenDone} = doneArr[cyc][3:0] | sp;
  endtask

  task automatic test_reset();
    drvReset = 1'b1;
    stepCycle();
    stepCycle();
    assertCount++;
    if (actVec() !== 46'd0) begin
      failCount++;
      $display("[TB] FAIL reset_state: actual %h, required %h", actVec(), 46'd0);
    end
    drvReset = 1'b0;
  endtask

  task automatic test_basic();
    int genAt, filtAt, envAt, dacAt;
    genAt = -1; filtAt = -1; envAt = -1; dacAt = -1;
    setDelays(1, 1, 1, 1);
    drvFreq = 24'd440000; drvVel = 7'd100; drvPlay = 1'b1;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL basic_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (genAt < 0 && outGenStart === 1'b1) genAt = cyc;
      if (filtAt < 0 && outFiltStart === 1'b1) filtAt = cyc;
      if (envAt < 0 && outEnvStart === 1'b1) envAt = cyc;
      if (dacAt < 0 && outDacStart === 1'b1) dacAt = cyc;
      if (cyc == 24) begin
        assertCount++;
        if (outBusy !== 1'b0 || outFrequency !== 24'd440000 || outOverrunCount !== 8'd0) begin
          failCount++;
          $display("[TB] FAIL basic_after_dac: actual busy=%b freq=%0d over=%0d, required busy=0 freq=440000 over=0",
                   outBusy, outFrequency, outOverrunCount);
        end
      end
    end
    assertCount++;
    if (genAt !== 16) begin
      failCount++;
      $display("[TB] FAIL basic_gen_start: actual cycle %0d, required 16", genAt);
    end
    assertCount++;
    if (filtAt !== 18 || envAt !== 20 || dacAt !== 22) begin
      failCount++;
      $display("[TB] FAIL basic_stage_starts: actual %0d/%0d/%0d, required 18/20/22", filtAt, envAt, dacAt);
    end
  endtask

  task automatic test_param_latch();
    bit changed, sawDac, sawNew;
    changed = 1'b0; sawDac = 1'b0; sawNew = 1'b0;
    setDelays(2, 2, 2, 2);
    drvVel = 7'd100;
    for (int i = 0; i < 48; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL latch_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (!changed && stageArr[cyc] == 2) begin
        drvVel  = 7'd20;
        changed = 1'b1;
      end
      if (changed && !sawDac && outDacStart === 1'b1) begin
        sawDac = 1'b1;
        assertCount++;
        if (outVelocity !== 7'd100) begin
          failCount++;
          $display("[TB] FAIL latch_hold: actual velocity %0d, required 100", outVelocity);
        end
      end
      if (sawDac && !sawNew && outGenStart === 1'b1) begin
        sawNew = 1'b1;
        assertCount++;
        if (outVelocity !== 7'd20) begin
          failCount++;
          $display("[TB] FAIL latch_next: actual velocity %0d, required 20", outVelocity);
        end
      end
    end
    assertCount++;
    if (!sawNew) begin
      failCount++;
      $display("[TB] FAIL latch_sequence: actual dac=%b next=%b, required both seen", sawDac, sawNew);
    end
  endtask

  task automatic test_timeout();
    int filtAt, toAt, genAfter;
    bit envSeen;
    filtAt = -1; toAt = -1; genAfter = -1; envSeen = 1'b0;
    setDelays(1, 99, 1, 1);
    for (int i = 0; i < 64 && genAfter < 0; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL timeout_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (filtAt < 0 && outFiltStart === 1'b1) filtAt = cyc;
      if (filtAt >= 0 && outEnvStart === 1'b1) envSeen = 1'b1;
      if (filtAt >= 0 && toAt < 0 && outTimeout === 1'b1) begin
        toAt = cyc;
        setDelays(1, 1, 1, 1);
        assertCount++;
        if (outBusy !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL timeout_idle: actual busy %b, required 0", outBusy);
        end
      end
      if (toAt >= 0 && cyc > toAt && outGenStart === 1'b1) genAfter = cyc;
    end
    assertCount++;
    if (filtAt < 0 || toAt - filtAt !== TOUT) begin
      failCount++;
      $display("[TB] FAIL timeout_delay: actual %0d cycles, required %0d", toAt - filtAt, TOUT);
    end
    assertCount++;
    if (envSeen) begin
      failCount++;
      $display("[TB] FAIL timeout_no_env: actual env start seen, required none");
    end
    assertCount++;
    if (genAfter < 0 || genAfter % TDIV != 0) begin
      failCount++;
      $display("[TB] FAIL timeout_restart: actual gen start cycle %0d, required next tick+1", genAfter);
    end
  endtask

  task automatic test_done_same_cycle();
    int genAt, nSamp;
    int expGap [2];
    expGap[0] = 1; expGap[1] = 4;
    genAt = -1; nSamp = 0;
    spurAll = 1'b1;
    setDelays(0, 1, 1, 1);
    for (int i = 0; i < 48; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL same_cycle_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (outGenStart === 1'b1) genAt = cyc;
      if (outFiltStart === 1'b1 && genAt >= 0 && nSamp < 2) begin
        assertCount++;
        if (cyc - genAt !== expGap[nSamp]) begin
          failCount++;
          $display("[TB] FAIL same_cycle_gap: actual %0d, required %0d", cyc - genAt, expGap[nSamp]);
        end
        nSamp++;
      end
      if (outDacStart === 1'b1 && nSamp == 1) setDelays(3, 1, 1, 1);
    end
    assertCount++;
    if (nSamp !== 2) begin
      failCount++;
      $display("[TB] FAIL same_cycle_samples: actual %0d, required 2", nSamp);
    end
    spurAll = 1'b0;
  endtask

  task automatic test_reset_mid_sequence();
    int envCycles, genAt;
    bit fired, dacSeen;
    envCycles = 0; fired = 1'b0; genAt = -1; dacSeen = 1'b0;
    setDelays(1, 1, 5, 1);
    for (int i = 0; i < 64 && !fired; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL midreset_pre at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (stageArr[cyc] == 3) envCycles++;
      if (envCycles == 2) begin
        drvReset = 1'b1;
        stepCycle();
        drvReset = 1'b0;
        fired = 1'b1;
      end
    end
    assertCount++;
    if (!fired) begin
      failCount++;
      $display("[TB] FAIL midreset_env: actual env cycles %0d, required 2", envCycles);
    end
    for (int i = 0; i < 24; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL midreset_post at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
      if (i == 0) begin
        assertCount++;
        if (actVec() !== 46'd0) begin
          failCount++;
          $display("[TB] FAIL midreset_clear: actual %h, required 0", actVec());
        end
      end
      if (outDacStart === 1'b1) dacSeen = 1'b1;
      if (genAt < 0 && outGenStart === 1'b1) genAt = cyc;
    end
    assertCount++;
    if (dacSeen || genAt !== 16) begin
      failCount++;
      $display("[TB] FAIL midreset_restart: actual dac=%b gen cycle %0d, required dac=0 gen cycle 16", dacSeen, genAt);
    end
  endtask

  task automatic test_overrun_saturation();
    drvReset = 1'b1;
    stepCycle();
    drvReset = 1'b0;
    setDelays(7, 7, 7, 7);
    for (int i = 0; i < TDIV * 420; i++) begin
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL overrun_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
    end
    assertCount++;
    if (outOverrunCount !== 8'd255) begin
      failCount++;
      $display("[TB] FAIL overrun_saturate: actual %0d, required 255", outOverrunCount);
    end
  endtask

  task automatic test_random();
    drvReset = 1'b1;
    stepCycle();
    drvReset = 1'b0;
    spurRand = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      delayLo[k] = 0;
      delayHi[k] = 9;
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) drvFreq = 24'($urandom);
      if ($urandom_range(3, 0) == 0) drvVel = 7'($urandom);
      if ($urandom_range(7, 0) == 0) drvPlay = 1'($urandom);
      stepCycle();
      assertCount++;
      if (actVec() !== expVec) begin
        failCount++;
        $display("[TB] FAIL random_cycle at cycle %0d: actual %h, required %h", cyc, actVec(), expVec);
      end
    end
    spurRand = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inFrequency = '0; inVelocity = '0; inPlaying = 1'b0;
    {inDacDone, inEnvDone, inFiltDone, inGenDone} = 4'b0000;
    drvReset = 1'b1; drvFreq = '0; drvVel = '0; drvPlay = 1'b0;
    setDelays(1, 1, 1, 1);
    test_reset();
    test_basic();
    test_param_latch();
    test_timeout();
    test_done_same_cycle();
    test_reset_mid_sequence();
    test_overrun_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    failCount++;
    $display("[TB] FAIL watchdog: actual time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
